mbox_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single byte-wide MAILBOX write port between NREQ word-level requesters, such as the CPU-side mailbox register and hardware status reporters. It latches a granted requester's 32-bit word and serialises 1–4 bytes, least-significant byte first, into the MAILBOX while honouring `mbox_full_i`. A lock input lets one requester keep the port across several consecutive words, so multi-word MAILBOX packets are never interleaved.

---
 rtl/mbox_wr_arbiter_pkg.sv | 22 ++
 rtl/mbox_wr_arbiter_if.sv | 31 +++
 rtl/mbox_rr_pick.sv | 31 +++
 rtl/mbox_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_mbox_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mbox_wr_arbiter_pkg.sv
// Shared types and helpers for the MAILBOX write-port arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mbox_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    localparam int MBOX_BYTES = 4;

    // Byte counts of 0 or above the word size mean "whole word".
    function automatic logic [2:0] decode_nbyte(input logic [2:0] n);
        if (n == 3'd0 || n > 3'(MBOX_BYTES)) begin
            return 3'(MBOX_BYTES);
        end
        return n;
    endfunction

endpackage

// File: rtl/mbox_wr_arbiter_if.sv
// Requester-side and MAILBOX-side signals of the write-port arbiter.
// Latency: n/a (wiring only).
// Backpressure: mbox_full_i stalls the byte stream.
interface mbox_wr_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
);
    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0]       lock_i;
    logic [NREQ*WB_DW-1:0] dat_i;
    logic [NREQ*3-1:0]     nbyte_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       ack_o;
    logic                  busy_o;
    logic                  mbox_wr_o;
    logic [WOU_DW-1:0]     mbox_do_o;
    logic                  mbox_full_i;

    // Arbiter side.
    modport slave (
        input  req_i, lock_i, dat_i, nbyte_i, mbox_full_i,
        output gnt_o, ack_o, busy_o, mbox_wr_o, mbox_do_o
    );

    // Requester / MAILBOX side.
    modport master (
        output req_i, lock_i, dat_i, nbyte_i, mbox_full_i,
        input  gnt_o, ack_o, busy_o, mbox_wr_o, mbox_do_o
    );
endinterface

// File: rtl/mbox_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module mbox_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    logic found;
    int   pos;

    // Scan NREQ slots starting at ptr and take the first requester seen.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = (int'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/mbox_wr_arbiter.sv
// Round-robin arbiter serialising one requester's word into the byte-wide MAILBOX, LSB first.
// Latency: request seen in cycle N, first byte written in cycle N+1; nbyte+1 cycles per word.
// Backpressure: mbox_full_i holds the current byte and freezes the word; lock keeps the grant.
module mbox_wr_arbiter
    import mbox_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    mbox_wr_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_q, state_nxt;
    logic [WB_DW-1:0]  shreg_q, shreg_nxt;
    logic [2:0]        cnt_q, cnt_nxt;
    logic [IW-1:0]     owner_q, owner_nxt;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_nxt;
    logic [NREQ-1:0]   gnt_q, gnt_nxt;
    logic              busy_q;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     sel_idx;
    logic [WB_DW-1:0]  sel_dat;
    logic [2:0]        sel_nbyte;
    logic [IW-1:0]     ptr_after_owner;
    logic              wr;
    logic [NREQ-1:0]   ack;

    mbox_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (bus.req_i),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // A new word comes from the fresh pick when idle, otherwise from the locked owner.
    assign sel_idx         = (state_q == ST_IDLE) ? pick_idx : owner_q;
    assign sel_dat         = bus.dat_i[sel_idx*WB_DW +: WB_DW];
    assign sel_nbyte       = decode_nbyte(bus.nbyte_i[sel_idx*3 +: 3]);
    assign ptr_after_owner = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);

    // Next-state, datapath updates, and the combinational write/ack strobes.
    always_comb begin
        state_nxt  = state_q;
        shreg_nxt  = shreg_q;
        cnt_nxt    = cnt_q;
        owner_nxt  = owner_q;
        gnt_nxt    = gnt_q;
        rr_ptr_nxt = rr_ptr_q;
        wr         = 1'b0;
        ack        = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    owner_nxt = pick_idx;
                    gnt_nxt   = pick_gnt;
                    shreg_nxt = sel_dat;
                    cnt_nxt   = sel_nbyte;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                wr = ~bus.mbox_full_i;
                if (wr) begin
                    shreg_nxt = shreg_q >> WOU_DW;
                    cnt_nxt   = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        ack = gnt_q;
                        if (bus.lock_i[owner_q]) begin
                            state_nxt = ST_HOLD;
                        end else begin
                            state_nxt  = ST_IDLE;
                            gnt_nxt    = '0;
                            rr_ptr_nxt = ptr_after_owner;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bus.req_i[owner_q]) begin
                    shreg_nxt = sel_dat;
                    cnt_nxt   = sel_nbyte;
                    state_nxt = ST_SEND;
                end else if (!bus.lock_i[owner_q]) begin
                    state_nxt  = ST_IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = ptr_after_owner;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial word.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            shreg_q  <= shreg_nxt;
            cnt_q    <= cnt_nxt;
            owner_q  <= owner_nxt;
            rr_ptr_q <= rr_ptr_nxt;
            gnt_q    <= gnt_nxt;
            busy_q   <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.ack_o     = ack;
    assign bus.busy_o    = busy_q;
    assign bus.mbox_wr_o = wr;
    assign bus.mbox_do_o = shreg_q[WOU_DW-1:0];
endmodule

// File: tb/tb_mbox_wr_arbiter.sv
// Directed bench for the MAILBOX write arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns after it.
// Each scenario task checks its own cycles inline.
module tb_mbox_wr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mbox_wr_arbiter_if #(.NREQ(2), .WB_DW(32), .WOU_DW(8)) bus ();

    mbox_wr_arbiter #(.NREQ(2), .WB_DW(32), .WOU_DW(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = '0; bus.lock_i = '0; bus.dat_i = '0; bus.nbyte_i = '0; bus.mbox_full_i = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({bus.gnt_o, bus.ack_o, bus.busy_o, bus.mbox_wr_o, bus.mbox_do_o} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_state: got gnt=%b ack=%b busy=%b wr=%b do=%h, want all zero",
                     bus.gnt_o, bus.ack_o, bus.busy_o, bus.mbox_wr_o, bus.mbox_do_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.dat_i[31:0] = 32'h44332211; bus.nbyte_i[2:0] = 3'd4; bus.req_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.gnt_o, bus.ack_o, bus.busy_o, bus.mbox_wr_o, bus.mbox_do_o} !==
                {2'b01, (i == 3) ? 2'b01 : 2'b00, 1'b1, 1'b1, exp_b[i]}) begin
                miscompares++;
                $display("FAIL single_byte%0d: got gnt=%b ack=%b busy=%b wr=%b do=%h, want gnt=01 ack=%b busy=1 wr=1 do=%h",
                         i, bus.gnt_o, bus.ack_o, bus.busy_o, bus.mbox_wr_o, bus.mbox_do_o,
                         (i == 3) ? 2'b01 : 2'b00, exp_b[i]);
            end
            if (i == 3) bus.req_i = 2'b00;
        end
        tick();
        vectors++;
        if ({bus.gnt_o, bus.busy_o, bus.mbox_wr_o} !== 4'b0) begin
            miscompares++;
            $display("FAIL single_idle: got gnt=%b busy=%b wr=%b, want 00/0/0", bus.gnt_o, bus.busy_o, bus.mbox_wr_o);
        end
    endtask

    task automatic test_backpressure();
        logic       full_s [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] do_s   [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
        logic [31:0] seen = '0;
        int         nwr = 0;
        bus.dat_i[31:0] = 32'h44332211; bus.nbyte_i[2:0] = 3'd4; bus.req_i = 2'b01;
        for (int c = 0; c < 7; c++) begin
            tick();
            bus.mbox_full_i = full_s[c];
            #1;
            vectors++;
            if ({bus.mbox_wr_o, bus.mbox_do_o, bus.ack_o} !== {~full_s[c], do_s[c], (c == 6) ? 2'b01 : 2'b00}) begin
                miscompares++;
                $display("FAIL bp_cycle%0d: got wr=%b do=%h ack=%b, want wr=%b do=%h ack=%b",
                         c, bus.mbox_wr_o, bus.mbox_do_o, bus.ack_o, ~full_s[c], do_s[c], (c == 6) ? 2'b01 : 2'b00);
            end
            if (bus.mbox_wr_o === 1'b1) begin
                if (nwr < 4) seen[nwr*8 +: 8] = bus.mbox_do_o;
                nwr++;
            end
            if (c == 6) bus.req_i = 2'b00;
        end
        vectors++;
        if (nwr != 4 || seen !== 32'h44332211) begin
            miscompares++;
            $display("FAIL bp_stream: got %0d writes bytes=%h, want 4 writes bytes=44332211", nwr, seen);
        end
        tick();
    endtask

    task automatic test_fairness();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dat_i = {32'h000000B1, 32'h000000A0};
        bus.nbyte_i = {3'd1, 3'd1};
        bus.req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] eg;
            logic [7:0] ed;
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            ed = (k % 2 == 0) ? 8'hA0 : 8'hB1;
            tick();
            vectors++;
            if ({bus.gnt_o, bus.ack_o, bus.mbox_wr_o, bus.mbox_do_o} !== {eg, eg, 1'b1, ed}) begin
                miscompares++;
                $display("FAIL fair_word%0d: got gnt=%b ack=%b wr=%b do=%h, want gnt=%b ack=%b wr=1 do=%h",
                         k, bus.gnt_o, bus.ack_o, bus.mbox_wr_o, bus.mbox_do_o, eg, eg, ed);
            end
            if (k == 3) bus.req_i = 2'b00;
            tick();
            vectors++;
            if ({bus.gnt_o, bus.mbox_wr_o} !== 3'b0) begin
                miscompares++;
                $display("FAIL fair_gap%0d: got gnt=%b wr=%b, want 00/0", k, bus.gnt_o, bus.mbox_wr_o);
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] eg  [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        logic [1:0] ea  [9] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [7:0] ed  [9] = '{8'hC1, 8'h00, 8'hC2, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'hD0};
        logic [1:0] nrq [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic [1:0] nlk [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [7:0] nd1 [9] = '{8'hC2, 8'hC2, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
        bus.dat_i = {32'h000000C1, 32'h000000D0};
        bus.nbyte_i = {3'd1, 3'd1};
        bus.lock_i = 2'b10;
        bus.req_i = 2'b10;
        for (int s = 0; s < 9; s++) begin
            logic ew;
            ew = (ea[s] != 2'b00);
            tick();
            vectors++;
            if ({bus.gnt_o, bus.ack_o, bus.mbox_wr_o, bus.busy_o} !== {eg[s], ea[s], ew, (eg[s] != 2'b00)} ||
                (ew && bus.mbox_do_o !== ed[s])) begin
                miscompares++;
                $display("FAIL lock_step%0d: got gnt=%b ack=%b wr=%b busy=%b do=%h, want gnt=%b ack=%b wr=%b do=%h",
                         s, bus.gnt_o, bus.ack_o, bus.mbox_wr_o, bus.busy_o, bus.mbox_do_o, eg[s], ea[s], ew, ed[s]);
            end
            bus.req_i = nrq[s];
            bus.lock_i = nlk[s];
            bus.dat_i[63:32] = {24'h0, nd1[s]};
        end
        tick();
        vectors++;
        if ({bus.gnt_o, bus.busy_o} !== 3'b0) begin
            miscompares++;
            $display("FAIL lock_idle: got gnt=%b busy=%b, want 00/0", bus.gnt_o, bus.busy_o);
        end
    endtask

    task automatic test_odd_sizes();
        logic [2:0] nb   [3] = '{3'd0, 3'd2, 3'd7};
        int         nexp [3] = '{4, 2, 4};
        logic [31:0] w = 32'hAABBCCDD;
        bus.dat_i[31:0] = w;
        for (int c = 0; c < 3; c++) begin
            bus.nbyte_i[2:0] = nb[c];
            bus.req_i = 2'b01;
            for (int i = 0; i < nexp[c]; i++) begin
                logic [7:0] eb;
                eb = w[i*8 +: 8];
                tick();
                vectors++;
                if ({bus.gnt_o, bus.mbox_wr_o, bus.ack_o, bus.mbox_do_o} !==
                    {2'b01, 1'b1, (i == nexp[c]-1) ? 2'b01 : 2'b00, eb}) begin
                    miscompares++;
                    $display("FAIL odd_nb%0d_byte%0d: got gnt=%b wr=%b ack=%b do=%h, want gnt=01 wr=1 ack=%b do=%h",
                             nb[c], i, bus.gnt_o, bus.mbox_wr_o, bus.ack_o, bus.mbox_do_o,
                             (i == nexp[c]-1) ? 2'b01 : 2'b00, eb);
                end
                if (i == nexp[c]-1) bus.req_i = 2'b00;
            end
            tick();
            vectors++;
            if ({bus.gnt_o, bus.mbox_wr_o} !== 3'b0) begin
                miscompares++;
                $display("FAIL odd_nb%0d_end: got gnt=%b wr=%b, want 00/0 (extra byte)", nb[c], bus.gnt_o, bus.mbox_wr_o);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.dat_i = {32'h00000055, 32'h44332211};
        bus.nbyte_i = {3'd1, 3'd4};
        bus.req_i = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({bus.mbox_wr_o, bus.mbox_do_o} !== {1'b1, exp_b[i]}) begin
                miscompares++;
                $display("FAIL rstmid_pre%0d: got wr=%b do=%h, want wr=1 do=%h", i, bus.mbox_wr_o, bus.mbox_do_o, exp_b[i]);
            end
        end
        #1;
        rst = 1'b1;
        bus.req_i = 2'b11;
        #1;
        vectors++;
        if ({bus.gnt_o, bus.ack_o, bus.busy_o, bus.mbox_wr_o, bus.mbox_do_o} !== 14'h0) begin
            miscompares++;
            $display("FAIL rstmid_async: got gnt=%b ack=%b busy=%b wr=%b do=%h, want all zero",
                     bus.gnt_o, bus.ack_o, bus.busy_o, bus.mbox_wr_o, bus.mbox_do_o);
        end
        tick();
        vectors++;
        if ({bus.ack_o, bus.mbox_wr_o} !== 3'b0) begin
            miscompares++;
            $display("FAIL rstmid_held: got ack=%b wr=%b, want 00/0", bus.ack_o, bus.mbox_wr_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.gnt_o, bus.mbox_wr_o, bus.mbox_do_o, bus.ack_o} !==
                {2'b01, 1'b1, exp_b[i], (i == 3) ? 2'b01 : 2'b00}) begin
                miscompares++;
                $display("FAIL rstmid_post%0d: got gnt=%b wr=%b do=%h ack=%b, want gnt=01 wr=1 do=%h ack=%b",
                         i, bus.gnt_o, bus.mbox_wr_o, bus.mbox_do_o, bus.ack_o, exp_b[i], (i == 3) ? 2'b01 : 2'b00);
            end
            if (i == 0) bus.req_i = 2'b10;
        end
        tick();
        vectors++;
        if (bus.gnt_o !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_gap: got gnt=%b, want 00", bus.gnt_o);
        end
        tick();
        vectors++;
        if ({bus.gnt_o, bus.ack_o, bus.mbox_do_o} !== {2'b10, 2'b10, 8'h55}) begin
            miscompares++;
            $display("FAIL rstmid_req1: got gnt=%b ack=%b do=%h, want gnt=10 ack=10 do=55", bus.gnt_o, bus.ack_o, bus.mbox_do_o);
        end
        bus.req_i = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_fairness();
        test_lock();
        test_odd_sizes();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
